median_filter_core: RTL and testbench
=====================================

MEDIAN_FILTER_CORE -- requirements
Module: median_filter_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits (4..16).
REQ-002 SHALL have parameter COL_NUM, default 320, pixels per line (>=3).
REQ-003 SHALL have parameter ROW_NUM, default 720, lines per frame (>=3).
REQ-004 SHALL have parameter THRESH, default 80, switching-median threshold (unsigned, DATA_W bits).
REQ-005 SHALL have port sclk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port pi_data  input  DATA_W  input pixel, raster order.
REQ-008 SHALL have port pi_flag  input  1  pi_data valid this cycle.
REQ-009 SHALL have port pi_sof  input  1  qualifies pi_flag: current pixel is frame pixel (0,0).
REQ-010 SHALL have port mode  input  1  0 = plain median, 1 = switching median.
REQ-011 SHALL have port po_data  output  DATA_W  filtered pixel.
REQ-012 SHALL have port po_flag  output  1  po_data valid.
REQ-013 SHALL have port po_sof  output  1  po_data is the output for input pixel (0,0).

Function
REQ-014 SHALL keep col_cnt (0..COL_NUM-1) and row_cnt (0..ROW_NUM-1) for the accepted pixel; advance only on pi_flag; col wraps to 0 and increments row; row wraps to 0 after ROW_NUM-1.
REQ-015 SHALL force the accepted pixel's position to (0,0) when pi_sof=1 with pi_flag=1, regardless of counter state.
REQ-016 SHALL hold two internal line buffers of COL_NUM x DATA_W, written/read only on pi_flag, forming a 3x3 window whose bottom-right element is the accepted pixel (r,c).
REQ-017 SHALL output, per accepted pixel, exactly one po_flag pulse, in order, exactly 4 cycles after its pi_flag (fixed latency, independent of gaps).
REQ-018 SHALL, when r<2 or c<2 (border), output the accepted pixel itself unchanged.
REQ-019 SHALL, otherwise, compute median of the 9 window pixels: per-row sort (max/mid/min), then median of {min of maxes, mid of mids, max of mins}; ties resolved by value, result exact.
REQ-020 SHALL, in mode 1 (non-border), output median if |centre - median| > THRESH, else centre, where centre = pixel (r-1,c-1); difference computed at DATA_W+1 bits, no wrap.
REQ-021 SHALL sample mode together with pi_flag and carry it down the pipeline; mode changes never affect in-flight pixels.
REQ-022 SHALL hold po_data at its last value while po_flag=0; po_flag low and pipeline idle when no input.
REQ-023 SHALL accept pi_flag on every cycle (no back-pressure); arbitrary gaps SHALL yield bit-identical output data to gapless input.

Reset
REQ-024 SHALL on rst_n=0 clear po_data, po_flag, po_sof, counters, window registers and all pipeline valid flags to 0 immediately.
REQ-025 SHALL drop pixels in flight at reset; no output pulse for them after release.
REQ-026 SHALL not require line-buffer contents reset; border rule (REQ-018) SHALL guarantee unwritten entries never reach po_data after a reset followed by pi_sof.

Configuration
REQ-027 SHALL implement switching median (REQ-020) only when MEDIAN_THRESH_EN is defined; with it undefined, mode SHALL be ignored and every non-border output SHALL be the plain median, port list unchanged.

Verification
REQ-028 COL_NUM=8, ROW_NUM=4, frame of constant 50, gapless -> 32 outputs all 50, each po_flag exactly 4 cycles after its pi_flag, po_sof on first only.
REQ-029 All pixels 10 except 255 at (2,2), mode 0 -> output for input (3,3) = 10, no output ever 255 except none (pixel (2,2) is non-border).
REQ-030 Ramp pi_data = 16*r + c -> every output with r<2 or c<2 equals its input; (2,2) output = 17.
REQ-031 MEDIAN_THRESH_EN defined, THRESH=20, mode 1, neighbours 20: centre 30 -> 30; centre 200 -> 20; same with macro undefined -> 20 for both.
REQ-032 Same frame as REQ-030 with pi_flag 1-0-0-1 gap pattern -> output sequence identical to gapless run.
REQ-033 Reset asserted after 13 pixels, released, new frame with pi_sof -> no stale outputs, new frame results match REQ-028 reference.

Source files
------------

// File: rtl/median_filter_core.sv
// median_filter_core: streaming 3x3 median filter for a raster pixel stream.
// Two line buffers and a 3x3 window register feed a three-stage sorting
// network. Each accepted pixel produces exactly one output 4 cycles later.
// Border pixels (row < 2 or col < 2) pass through unchanged.
// Build macro MEDIAN_THRESH_EN adds the switching-median mode. When it is not
// defined, the mode input is ignored.
module median_filter_core #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned COL_NUM = 320,
    parameter int unsigned ROW_NUM = 720,
    parameter int unsigned THRESH  = 80
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pi_data,
    input  logic              pi_flag,
    input  logic              pi_sof,
    input  logic              mode,
    output logic [DATA_W-1:0] po_data,
    output logic              po_flag,
    output logic              po_sof
);

    localparam int unsigned COL_W = $clog2(COL_NUM);
    localparam int unsigned ROW_W = $clog2(ROW_NUM);

    typedef logic [DATA_W-1:0] pix_t;

    localparam pix_t THRESH_W = pix_t'(THRESH);

    // Side information that travels with each pixel down the pipeline.
    typedef struct packed {
        logic vld;
        logic sof;
        logic mode;
        logic border;
    } ctl_t;

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
        return max2(max2(a, b), c);
    endfunction

    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        return min2(min2(a, b), c);
    endfunction

    function automatic pix_t mid3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // ------------------------------------------------------------------
    // Position tracking
    // ------------------------------------------------------------------
    logic [COL_W-1:0] col_q, col_d, pos_col;
    logic [ROW_W-1:0] row_q, row_d, pos_row;

    // Work out the position of the presented pixel (sof forces 0,0) and advance the counters.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        pos_col = col_q;
        pos_row = row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (pi_sof) begin
            pos_col = '0;
            pos_row = '0;
        end
        if (pi_flag) begin
            if (pos_col == COL_W'(COL_NUM - 1)) begin
                col_d = '0;
                row_d = (pos_row == ROW_W'(ROW_NUM - 1)) ? '0 : pos_row + ROW_W'(1);
            end else begin
                col_d = pos_col + COL_W'(1);
                row_d = pos_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb0 holds row r-1, lb1 holds row r-2
    // ------------------------------------------------------------------
    pix_t lb0_q [COL_NUM];
    pix_t lb1_q [COL_NUM];
    pix_t up1_rd, up2_rd;

    assign up1_rd = lb0_q[pos_col];
    assign up2_rd = lb1_q[pos_col];

    // On each accepted pixel, push the column down: new pixel into lb0, old lb0 entry into lb1.
    always_ff @(posedge sclk) begin
        // NOTE: the buffers have no reset. Stale entries only ever reach border positions, and border positions bypass the median.
        if (pi_flag) begin
            lb0_q[pos_col] <= pi_data;
            lb1_q[pos_col] <= up1_rd;
        end
    end

    // ------------------------------------------------------------------
    // 3x3 window: [row][col], row 2 / col 2 is the newest pixel
    // ------------------------------------------------------------------
    pix_t win_q [3][3];
    pix_t win_d [3][3];
    ctl_t s1_d, s1_q;

    // Shift the window left by one column on each accepted pixel.
    always_comb begin
        win_d = win_q;
        if (pi_flag) begin
            for (int k = 0; k < 3; k++) begin
                win_d[k][0] = win_q[k][1];
                win_d[k][1] = win_q[k][2];
            end
            win_d[0][2] = up2_rd;
            win_d[1][2] = up1_rd;
            win_d[2][2] = pi_data;
        end
    end

    // Stage-1 control bits, sampled together with the pixel.
    always_comb begin
        s1_d.vld    = pi_flag;
        s1_d.sof    = pi_flag & pi_sof;
        s1_d.mode   = mode;
        s1_d.border = (pos_row < ROW_W'(2)) || (pos_col < COL_W'(2));
    end

    // Register the counters, the window and the stage-1 control bits.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            s1_q  <= '0;
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[k][j] <= '0;
                end
            end
        end else begin
            // NOTE: state uses non-blocking assignments, so every register here samples values from before the edge.
            col_q <= col_d;
            row_q <= row_d;
            s1_q  <= s1_d;
            win_q <= win_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: sort each window row into max / mid / min
    // ------------------------------------------------------------------
    ctl_t s2_q;
    pix_t s2_raw_q, s2_ctr_q;
    pix_t s2_max_q [3];
    pix_t s2_mid_q [3];
    pix_t s2_min_q [3];

    // Sort each row of the window captured one cycle after acceptance.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            s2_q     <= '0;
            s2_raw_q <= '0;
            s2_ctr_q <= '0;
            for (int k = 0; k < 3; k++) begin
                s2_max_q[k] <= '0;
                s2_mid_q[k] <= '0;
                s2_min_q[k] <= '0;
            end
        end else begin
            s2_q     <= s1_q;
            s2_raw_q <= win_q[2][2];
            s2_ctr_q <= win_q[1][1];
            for (int k = 0; k < 3; k++) begin
                s2_max_q[k] <= max3(win_q[k][0], win_q[k][1], win_q[k][2]);
                s2_mid_q[k] <= mid3(win_q[k][0], win_q[k][1], win_q[k][2]);
                s2_min_q[k] <= min3(win_q[k][0], win_q[k][1], win_q[k][2]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: min of maxes, mid of mids, max of mins
    // ------------------------------------------------------------------
    ctl_t s3_q;
    pix_t s3_raw_q, s3_ctr_q, s3_hi_q, s3_md_q, s3_lo_q;

    // Reduce the nine sorted values to the three median candidates.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            s3_q     <= '0;
            s3_raw_q <= '0;
            s3_ctr_q <= '0;
            s3_hi_q  <= '0;
            s3_md_q  <= '0;
            s3_lo_q  <= '0;
        end else begin
            s3_q     <= s2_q;
            s3_raw_q <= s2_raw_q;
            s3_ctr_q <= s2_ctr_q;
            s3_hi_q  <= min3(s2_max_q[0], s2_max_q[1], s2_max_q[2]);
            s3_md_q  <= mid3(s2_mid_q[0], s2_mid_q[1], s2_mid_q[2]);
            s3_lo_q  <= max3(s2_min_q[0], s2_min_q[1], s2_min_q[2]);
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: final median, optional switching and output register
    // ------------------------------------------------------------------
    pix_t med, sel;

    assign med = mid3(s3_hi_q, s3_md_q, s3_lo_q);

`ifdef MEDIAN_THRESH_EN
    logic [DATA_W:0] diff;

    // The absolute difference uses one extra bit so that it cannot wrap.
    always_comb begin
        diff = (s3_ctr_q >= med) ? ({1'b0, s3_ctr_q} - {1'b0, med})
                                 : ({1'b0, med} - {1'b0, s3_ctr_q});
    end

    assign sel = (s3_q.mode && (diff <= {1'b0, THRESH_W})) ? s3_ctr_q : med;
`else
    // The plain-median build deliberately ignores mode, the centre pixel and the threshold.
    logic unused_sw;
    assign unused_sw = ^{s3_q.mode, s3_ctr_q, THRESH_W};
    assign sel       = med;
`endif

    pix_t po_data_q, po_data_d;
    logic po_flag_q, po_flag_d, po_sof_q, po_sof_d;

    // Choose the output pixel. po_data holds its value between valid outputs.
    always_comb begin
        po_flag_d = s3_q.vld;
        po_sof_d  = s3_q.vld & s3_q.sof;
        po_data_d = po_data_q;
        if (s3_q.vld) begin
            po_data_d = s3_q.border ? s3_raw_q : sel;
        end
    end

    // Output register.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            po_data_q <= '0;
            po_flag_q <= 1'b0;
            po_sof_q  <= 1'b0;
        end else begin
            po_data_q <= po_data_d;
            po_flag_q <= po_flag_d;
            po_sof_q  <= po_sof_d;
        end
    end

    assign po_data = po_data_q;
    assign po_flag = po_flag_q;
    assign po_sof  = po_sof_q;

endmodule

// File: tb/tb_median_filter_core.sv
// Testbench for median_filter_core using a small 8x4 frame and THRESH = 20.
// A scoreboard checks every output for value, sof and the exact 4-cycle latency.
// Expected values come from a sort-based reference model.
module tb_median_filter_core;

    localparam int DW   = 8;
    localparam int COLS = 8;
    localparam int ROWS = 4;
    localparam int TH   = 20;

    logic          sclk    = 1'b0;
    logic          rst_n   = 1'b0;
    logic [DW-1:0] pi_data = '0;
    logic          pi_flag = 1'b0;
    logic          pi_sof  = 1'b0;
    logic          mode    = 1'b0;
    logic [DW-1:0] po_data;
    logic          po_flag;
    logic          po_sof;

    median_filter_core #(
        .DATA_W (DW),
        .COL_NUM(COLS),
        .ROW_NUM(ROWS),
        .THRESH (TH)
    ) dut (
        .sclk   (sclk),
        .rst_n  (rst_n),
        .pi_data(pi_data),
        .pi_flag(pi_flag),
        .pi_sof (pi_sof),
        .mode   (mode),
        .po_data(po_data),
        .po_flag(po_flag),
        .po_sof (po_sof)
    );

    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Frame under test and the reference model
    int frame    [ROWS][COLS];
    bit mode_arr [ROWS][COLS];
    int got      [ROWS][COLS];
    int ref_got  [ROWS][COLS];

    function automatic int exp_pixel(input int r, input int c);
        int q[$];
        int med;
        if (r < 2 || c < 2) return frame[r][c];
        for (int dr = -2; dr <= 0; dr++)
            for (int dc = -2; dc <= 0; dc++)
                q.push_back(frame[r+dr][c+dc]);
        q.sort();
        med = q[4];
`ifdef MEDIAN_THRESH_EN
        begin
            int ctr, diff;
            ctr  = frame[r-1][c-1];
            diff = (ctr > med) ? ctr - med : med - ctr;
            if (mode_arr[r][c] && diff <= TH) return ctr;
        end
`endif
        return med;
    endfunction

    // Scoreboard and monitor
    typedef struct {
        int data;
        bit sof;
        int due;
        int r;
        int c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   edge_cnt  = 0;
    int   last_data = 0;

    always @(posedge sclk) edge_cnt <= edge_cnt + 1;

    always @(negedge sclk) begin
        if (!rst_n) begin
            last_data = 0;
        end else if (po_flag) begin
            if (sb.size() == 0) begin
                check("unexpected_po_flag", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("po_data(%0d,%0d)", mon_e.r, mon_e.c), po_data, mon_e.data);
                check($sformatf("po_sof(%0d,%0d)", mon_e.r, mon_e.c), po_sof, mon_e.sof);
                check($sformatf("latency(%0d,%0d)", mon_e.r, mon_e.c), edge_cnt, mon_e.due);
                got[mon_e.r][mon_e.c] = po_data;
            end
            last_data = po_data;
        end else begin
            check("po_data_hold", po_data, last_data);
            check("po_sof_idle", po_sof, 0);
        end
    end

    task automatic fill(input int val, input bit md);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                frame[r][c]    = val;
                mode_arr[r][c] = md;
            end
    endtask

    task automatic clear_got();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                got[r][c] = -1;
    endtask

    // gap_kind: 0 gapless, 1 pattern 1-0-0-1, 2 random gaps with noise on idle inputs
    task automatic send_frame(input int npix, input int gap_kind);
        for (int i = 0; i < npix; i++) begin
            int r, c, ngap;
            r = i / COLS;
            c = i % COLS;
            ngap = (gap_kind == 1) ? 2 : (gap_kind == 2) ? int'($urandom_range(0, 3)) : 0;
            if (i > 0) begin
                repeat (ngap) begin
                    @(negedge sclk);
                    pi_flag = 1'b0;
                    pi_sof  = 1'($urandom);
                    mode    = 1'($urandom);
                    pi_data = 8'($urandom);
                end
            end
            @(negedge sclk);
            pi_flag = 1'b1;
            pi_sof  = (i == 0);
            pi_data = 8'(frame[r][c]);
            mode    = mode_arr[r][c];
            sb.push_back('{data: exp_pixel(r, c), sof: (i == 0), due: edge_cnt + 4, r: r, c: c});
        end
        @(negedge sclk);
        pi_flag = 1'b0;
        pi_sof  = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 40;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge sclk);
            budget--;
        end
        check("drain_pending", sb.size(), 0);
        sb.delete();
        repeat (6) @(negedge sclk);
    endtask

    function automatic int count_val(input int v);
        int n;
        n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (got[r][c] == v) n++;
        return n;
    endfunction

    typedef struct {
        int nb;
        int centre;
        bit md;
        int exp_sw;
        int exp_plain;
    } vec_t;

    vec_t tbl[10];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reference windows: 8 neighbours, centre placed at (1,1), result read at (2,2)
        tbl[0] = '{20,  30, 1'b1,  30,  20};
        tbl[1] = '{20, 200, 1'b1,  20,  20};
        tbl[2] = '{20, 200, 1'b0,  20,  20};
        tbl[3] = '{20,  30, 1'b0,  20,  20};
        tbl[4] = '{20,  40, 1'b1,  40,  20};
        tbl[5] = '{20,  41, 1'b1,  20,  20};
        tbl[6] = '{21,   0, 1'b1,  21,  21};
        tbl[7] = '{10, 255, 1'b0,  10,  10};
        tbl[8] = '{255,  0, 1'b1, 255, 255};
        tbl[9] = '{100, 90, 1'b1,  90, 100};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge sclk);
        check("reset_po_flag", po_flag, 0);
        check("reset_po_sof", po_sof, 0);
        check("reset_po_data", po_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge sclk);

        // Constant frame
        fill(50, 1'b0);
        clear_got();
        send_frame(ROWS * COLS, 0);
        drain();
        check("const50_count", count_val(50), ROWS * COLS);

        // Table-driven window cases
        for (int i = 0; i < 10; i++) begin
            int exp_v;
            fill(tbl[i].nb, tbl[i].md);
            frame[1][1] = tbl[i].centre;
            clear_got();
            send_frame(ROWS * COLS, 0);
            drain();
`ifdef MEDIAN_THRESH_EN
            exp_v = tbl[i].exp_sw;
`else
            exp_v = tbl[i].exp_plain;
`endif
            check($sformatf("vec%0d_out22", i), got[2][2], exp_v);
        end

        // Impulse at (2,2)
        fill(10, 1'b0);
        frame[2][2] = 255;
        clear_got();
        send_frame(ROWS * COLS, 0);
        drain();
        check("impulse_out33", got[3][3], 10);
        check("impulse_no255", count_val(255), 0);

        // Ramp, gapless then with 1-0-0-1 gaps
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                frame[r][c]    = 16 * r + c;
                mode_arr[r][c] = 1'b0;
            end
        clear_got();
        send_frame(ROWS * COLS, 0);
        drain();
        check("ramp_out22", got[2][2], 17);
        check("ramp_border00", got[0][0], 0);
        check("ramp_border17", got[1][7], 23);
        check("ramp_border30", got[3][0], 48);
        ref_got = got;
        clear_got();
        send_frame(ROWS * COLS, 1);
        drain();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                check($sformatf("gap_vs_gapless(%0d,%0d)", r, c), got[r][c], ref_got[r][c]);

        // Partial frame, then a new frame restarted by pi_sof without reset
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                frame[r][c]    = int'($urandom_range(0, 255));
                mode_arr[r][c] = 1'($urandom);
            end
        send_frame(13, 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                frame[r][c] = int'($urandom_range(0, 255));
        send_frame(ROWS * COLS, 0);
        drain();

        // Random frames with random modes and gaps
        for (int f = 0; f < 6; f++) begin
            int base;
            base = int'($urandom_range(0, 200));
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    frame[r][c]    = (f < 3) ? int'($urandom_range(0, 255))
                                             : base + int'($urandom_range(0, 55));
                    mode_arr[r][c] = 1'($urandom);
                end
            send_frame(ROWS * COLS, 2);
            drain();
        end

        // Reset after 13 pixels, then a fresh constant frame
        fill(50, 1'b0);
        send_frame(13, 0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midreset_po_flag", po_flag, 0);
        check("midreset_po_sof", po_sof, 0);
        check("midreset_po_data", po_data, 0);
        repeat (4) @(negedge sclk);
        rst_n = 1'b1;
        repeat (8) @(negedge sclk);
        fill(50, 1'b0);
        clear_got();
        send_frame(ROWS * COLS, 0);
        drain();
        check("postreset_const50_count", count_val(50), ROWS * COLS);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
